// File: rtl/tick_pwm_generator_if.sv
// Signal bundle between the tick PWM generator and whatever drives it.
// cfg_load is a one-cycle strobe with no ready: the core always accepts it on the cycle it is seen.
interface tick_pwm_generator_if #(
    parameter int WIDTH = 8
);
    logic             tick_in;
    logic             enable;
    logic [WIDTH-1:0] duty_in;
    logic [WIDTH-1:0] period_in;
    logic             cfg_load;
    logic             pwm_out;
    logic [WIDTH-1:0] tick_count;
    logic             cycle_done;
    logic             busy;
    logic             cfg_err;
    logic [1:0]       state;

    modport master (
        output tick_in, enable, duty_in, period_in, cfg_load,
        input  pwm_out, tick_count, cycle_done, busy, cfg_err, state
    );

    modport slave (
        input  tick_in, enable, duty_in, period_in, cfg_load,
        output pwm_out, tick_count, cycle_done, busy, cfg_err, state
    );
endinterface

// File: rtl/tick_pwm_generator.sv
// PWM generator clocked by rising edges of a slow divided level signal.
// Duty and period changes are shadowed and only take effect on a period boundary.
module tick_pwm_generator #(
    parameter int WIDTH      = 8,
    parameter int PERIOD_RST = 10,
    parameter int DUTY_RST   = 5
) (
    input logic                 clk,
    input logic                 rst,
    tick_pwm_generator_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    logic             tick_q;
    logic [WIDTH-1:0] tick_count;
    logic             pwm_q;
    logic             cycle_done_q;
    logic             cfg_err_q;
    logic [WIDTH-1:0] period_act;
    logic [WIDTH-1:0] duty_act;
    logic [WIDTH-1:0] shadow_period;
    logic [WIDTH-1:0] shadow_duty;
    logic             pending;

    logic             rise;
    logic             active;
    logic             wrap;
    logic             transfer;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] duty_eff;

    // >= rather than == keeps the counter bounded even if period_act shrank under it.
    always_comb begin
        rise       = bus.tick_in & ~tick_q;
        active     = (state == RUN) || (state == DRAIN);
        wrap       = active && rise && (tick_count >= (period_act - WIDTH'(1)));
        transfer   = pending && (wrap || ((state == IDLE) && bus.enable));
        duty_eff   = transfer ? shadow_duty : duty_act;
        count_next = tick_count;
        if (rise) begin
            count_next = wrap ? '0 : tick_count + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            tick_q        <= 1'b0;
            tick_count    <= '0;
            pwm_q         <= 1'b0;
            cycle_done_q  <= 1'b0;
            cfg_err_q     <= 1'b0;
            period_act    <= WIDTH'(PERIOD_RST);
            shadow_period <= WIDTH'(PERIOD_RST);
            duty_act      <= WIDTH'(DUTY_RST);
            shadow_duty   <= WIDTH'(DUTY_RST);
            pending       <= 1'b0;
        end else begin
            tick_q       <= bus.tick_in;
            cycle_done_q <= 1'b0;

            if (transfer) begin
                period_act <= shadow_period;
                duty_act   <= shadow_duty;
                pending    <= 1'b0;
            end
            // A load coinciding with a transfer lands after it and stays pending.
            if (bus.cfg_load) begin
                if (bus.period_in != '0) begin
                    shadow_period <= bus.period_in;
                    shadow_duty   <= bus.duty_in;
                    pending       <= 1'b1;
                end else begin
                    cfg_err_q <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    tick_count <= '0;
                    pwm_q      <= 1'b0;
                    if (bus.enable) state <= RUN;
                end
                RUN, DRAIN: begin
                    tick_count   <= count_next;
                    cycle_done_q <= wrap;
                    if (state == DRAIN && wrap && !bus.enable) begin
                        state <= IDLE;
                        pwm_q <= 1'b0;
                    end else begin
                        pwm_q <= (count_next < duty_eff);
                        state <= bus.enable ? RUN : DRAIN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pwm_out    = pwm_q;
    assign bus.tick_count = tick_count;
    assign bus.cycle_done = cycle_done_q;
    assign bus.busy       = active;
    assign bus.cfg_err    = cfg_err_q;
    assign bus.state      = state;
endmodule

// File: tb/tb_tick_pwm_generator.sv
// Directed bench for tick_pwm_generator: ticks are 10-high/10-low pulses on tick_in,
// i.e. one rise every 20 clk as from a divide-by-CONST=10 upstream stage.
module tb_tick_pwm_generator;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   done_cnt;
    int   high_cnt;
    int   done_snap;
    int   high_snap;

    tick_pwm_generator_if #(.WIDTH(WIDTH)) bus_i ();

    tick_pwm_generator #(
        .WIDTH(WIDTH),
        .PERIOD_RST(10),
        .DUTY_RST(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_i)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_i.cycle_done === 1'b1) done_cnt++;
        if (bus_i.pwm_out === 1'b1) high_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // driver tasks; all are entered and left on a falling edge
    task automatic tick_pulse();
        bus_i.tick_in = 1'b1;
        repeat (10) @(negedge clk);
        bus_i.tick_in = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) tick_pulse();
    endtask

    task automatic load(input int p, input int d);
        bus_i.period_in = WIDTH'(p);
        bus_i.duty_in   = WIDTH'(d);
        bus_i.cfg_load  = 1'b1;
        @(negedge clk);
        bus_i.cfg_load  = 1'b0;
    endtask

    task automatic snap();
        done_snap = done_cnt;
        high_snap = high_cnt;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        done_cnt        = 0;
        high_cnt        = 0;
        rst             = 1'b0;
        bus_i.tick_in   = 1'b0;
        bus_i.enable    = 1'b1;
        bus_i.cfg_load  = 1'b0;
        bus_i.duty_in   = '0;
        bus_i.period_in = '0;

        // reset held while tick_in toggles
        for (int i = 0; i < 6; i++) begin
            repeat (3) @(negedge clk);
            bus_i.tick_in = ~bus_i.tick_in;
        end
        bus_i.tick_in = 1'b0;
        @(negedge clk);
        check("rst_count", 32'(bus_i.tick_count), 0);
        check("rst_pwm",   32'(bus_i.pwm_out), 0);
        check("rst_done",  32'(bus_i.cycle_done), 0);
        check("rst_busy",  32'(bus_i.busy), 0);
        check("rst_err",   32'(bus_i.cfg_err), 0);
        check("rst_state", 32'(bus_i.state), 0);

        // default period 10 / duty 5
        rst = 1'b1;
        @(negedge clk);
        check("entry_busy",  32'(bus_i.busy), 1);
        check("entry_count", 32'(bus_i.tick_count), 0);
        @(negedge clk);
        check("entry_pwm", 32'(bus_i.pwm_out), 1);
        for (int t = 1; t < 10; t++) begin
            tick_pulse();
            check("def_count", 32'(bus_i.tick_count), 32'(t));
            check("def_pwm",   32'(bus_i.pwm_out), 32'(t < 5));
        end
        snap();
        tick_pulse();
        check("def_wrap",      32'(bus_i.tick_count), 0);
        check("def_wrap_done", 32'(done_cnt - done_snap), 1);
        snap();
        pulses(10);
        check("def_period_done", 32'(done_cnt - done_snap), 1);
        check("def_period_high", 32'(high_cnt - high_snap), 100);
        check("def_period_cnt",  32'(bus_i.tick_count), 0);

        // a level held high counts once
        bus_i.tick_in = 1'b1;
        repeat (50) @(negedge clk);
        bus_i.tick_in = 1'b0;
        repeat (10) @(negedge clk);
        check("hold_once", 32'(bus_i.tick_count), 1);

        // shadow load mid-period
        pulses(2);
        load(4, 1);
        check("load_mid_count", 32'(bus_i.tick_count), 3);
        check("load_mid_pwm",   32'(bus_i.pwm_out), 1);
        for (int t = 4; t < 10; t++) begin
            tick_pulse();
            check("old_cfg_count", 32'(bus_i.tick_count), 32'(t));
        end
        tick_pulse();
        check("new_cfg_wrap", 32'(bus_i.tick_count), 0);
        check("new_cfg_pwm0", 32'(bus_i.pwm_out), 1);
        snap();
        for (int i = 1; i <= 4; i++) begin
            tick_pulse();
            check("p4_count", 32'(bus_i.tick_count), 32'(i % 4));
            check("p4_pwm",   32'(bus_i.pwm_out), 32'((i % 4) == 0));
        end
        check("p4_done", 32'(done_cnt - done_snap), 1);
        check("p4_high", 32'(high_cnt - high_snap), 20);

        // duty 0
        load(10, 0);
        pulses(4);
        check("d0_wrap_pwm", 32'(bus_i.pwm_out), 0);
        snap();
        pulses(10);
        check("d0_high",  32'(high_cnt - high_snap), 0);
        check("d0_done",  32'(done_cnt - done_snap), 1);
        check("d0_count", 32'(bus_i.tick_count), 0);

        // duty above period
        load(10, 12);
        pulses(10);
        snap();
        pulses(10);
        check("d12_high", 32'(high_cnt - high_snap), 200);
        check("d12_pwm",  32'(bus_i.pwm_out), 1);

        // zero period rejected, active settings kept
        load(0, 3);
        check("err_set", 32'(bus_i.cfg_err), 1);
        snap();
        pulses(10);
        check("err_keep_high", 32'(high_cnt - high_snap), 200);
        check("err_keep_done", 32'(done_cnt - done_snap), 1);
        check("err_keep_cnt",  32'(bus_i.tick_count), 0);
        check("err_sticky",    32'(bus_i.cfg_err), 1);
        load(10, 5);
        pulses(10);

        // drain to idle
        pulses(6);
        bus_i.enable = 1'b0;
        @(negedge clk);
        check("drain_state", 32'(bus_i.state), 2);
        pulses(3);
        check("drain_count", 32'(bus_i.tick_count), 9);
        check("drain_busy",  32'(bus_i.busy), 1);
        snap();
        tick_pulse();
        check("drain_done",  32'(done_cnt - done_snap), 1);
        check("idle_busy",   32'(bus_i.busy), 0);
        check("idle_count",  32'(bus_i.tick_count), 0);
        check("idle_pwm",    32'(bus_i.pwm_out), 0);
        check("idle_state",  32'(bus_i.state), 0);
        tick_pulse();
        check("idle_nocount", 32'(bus_i.tick_count), 0);

        // re-enable during drain
        bus_i.enable = 1'b1;
        repeat (2) @(negedge clk);
        pulses(6);
        bus_i.enable = 1'b0;
        @(negedge clk);
        pulses(2);
        check("redrain_count", 32'(bus_i.tick_count), 8);
        bus_i.enable = 1'b1;
        @(negedge clk);
        check("resume_state", 32'(bus_i.state), 1);
        check("resume_count", 32'(bus_i.tick_count), 8);
        tick_pulse();
        check("resume_next", 32'(bus_i.tick_count), 9);

        // async reset mid-period with a pending load
        pulses(8);
        check("pre_rst_count", 32'(bus_i.tick_count), 7);
        check("pre_rst_pwm",   32'(bus_i.pwm_out), 0);
        load(4, 1);
        @(posedge clk);
        #2;
        bus_i.tick_in = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_count", 32'(bus_i.tick_count), 0);
        check("async_busy",  32'(bus_i.busy), 0);
        check("async_pwm",   32'(bus_i.pwm_out), 0);
        check("async_err",   32'(bus_i.cfg_err), 0);
        bus_i.tick_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        pulses(4);
        check("restore_count", 32'(bus_i.tick_count), 4);
        check("restore_pwm4",  32'(bus_i.pwm_out), 1);
        tick_pulse();
        check("restore_pwm5",  32'(bus_i.pwm_out), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tick_pwm_generator.md
Name: tick_pwm_generator

Overview:
- Downstream consumer of the clock-split/divider stage's `out` level signal.
- Detects rising edges of that divided signal and uses each one as a slow tick.
- Counts ticks modulo a programmable period and drives a PWM output with programmable duty.
- Duty and period updates are double-buffered so they apply only at period boundaries, giving glitch-free PWM for the LED/actuator stage that follows.

Parameters:
- WIDTH, 8: width of tick counter, duty and period registers.
- PERIOD_RST, 10: active period, in ticks, after reset. Must be ≥1.
- DUTY_RST, 5: active duty, in ticks, after reset.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- tick_in  in  1  divided level signal from the upstream split stage, synchronous to clk.
- enable  in  1  1 = generate PWM; 0 = finish the current period, then idle.
- duty_in  in  WIDTH  requested duty, in ticks.
- period_in  in  WIDTH  requested period, in ticks.
- cfg_load  in  1  1-cycle strobe; captures duty_in/period_in into the shadow registers.
- pwm_out  out  1  PWM output, registered.
- tick_count  out  WIDTH  current tick position within the period, registered.
- cycle_done  out  1  1-cycle pulse at each period wrap.
- busy  out  1  1 while in RUN or DRAIN.
- cfg_err  out  1  sticky flag, set when a load with period_in==0 is attempted.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, tick_q=0, tick_count=0, pwm_out=0, cycle_done=0, busy=0, cfg_err=0.
  - period_act=shadow_period=PERIOD_RST; duty_act=shadow_duty=DUTY_RST; pending=0.
  - Reset mid-period aborts immediately; no drain.
- Edge detect:
  - tick_q <= tick_in every cycle.
  - rise = tick_in & ~tick_q.
  - Only a 0→1 transition counts; a level held high counts once.
- Config load:
  - On cfg_load with period_in≠0: shadow_period<=period_in, shadow_duty<=duty_in, pending<=1.
  - On cfg_load with period_in==0: shadows unchanged, cfg_err<=1. cfg_err clears only by reset.
  - A second load before the boundary overwrites the shadows; last load wins.
- Shadow transfer: when pending=1, shadow→active transfer happens on a period wrap, or on IDLE→RUN entry. pending clears in the same cycle.
- FSM:
  - IDLE:
    - pwm_out=0, tick_count=0.
    - enable=1 → RUN next cycle; tick_count starts at 0.
  - RUN:
    - On rise: if tick_count==period_act-1, then tick_count<=0 and cycle_done<=1; else tick_count<=tick_count+1.
    - enable=0 → DRAIN.
  - DRAIN:
    - Counts like RUN.
    - On the wrap: go to IDLE, pulse cycle_done.
    - enable=1 during DRAIN → back to RUN, with no gap.
- PWM:
  - pwm_out is registered and updated every cycle in RUN/DRAIN as (count_next < duty_act), where count_next is the value tick_count takes that cycle.
  - duty_act=0 → constantly 0.
  - duty_act ≥ period_act → constantly 1 while busy.
- Latency: pwm_out and tick_count change on the clk edge where rise is sampled, i.e. one clk after tick_in goes high.
- Simultaneous events:
  - cfg_load in the same cycle as a wrap: the wrap transfers the old shadow, then the new load is captured as pending. It takes effect at the next wrap.
  - rise in the same cycle as enable 1→0: the tick is counted, then the state moves to DRAIN.
- Arithmetic: unsigned; tick_count never exceeds period_act-1.
- busy=1 in RUN/DRAIN.

Test Plan:
- Reset/defaults:
  - Stimulus: rst=0 with tick_in toggling.
  - Required: all outputs 0, no counting.
  - Then release rst, enable=1, upstream CONST=10 (rise every 20 clk).
  - Required: tick_count cycles 0..9, pwm_out high for ticks 0..4 (100 clk) and low for 100 clk, cycle_done pulses once every 200 clk.
- Edge detection: hold tick_in=1 for 50 clk → tick_count advances exactly once.
- Shadow load:
  - Stimulus: mid-period (tick_count=3), load period=4, duty=1.
  - Required: current period completes at 10 ticks; the next period shows pwm high for 1 tick, low for 3 ticks; cycle_done every 80 clk.
- Boundaries:
  - duty=0 → pwm_out stuck 0.
  - duty=12 with period=10 → pwm_out stuck 1 while busy.
  - Load with period_in=0 → cfg_err=1, active settings unchanged.
- Drain:
  - Stimulus: drop enable at tick_count=6.
  - Required: busy stays 1 until the wrap, cycle_done pulses, then IDLE with pwm_out=0 and tick_count=0.
  - Variant: re-raise enable at tick_count=8 → continues in RUN with no reset of the count.
- Reset mid-operation: assert rst at tick_count=7 with pwm_out=0 → outputs zero asynchronously (before next clk edge); pending load discarded; defaults restored.
